// File: rtl/pht_update_queue.sv
// pht_update_queue: buffers resolved conditional-branch outcomes and
// replays them as gshare PHT counter writes whenever the port is granted.
module pht_update_queue #(
    parameter int QUEUE_SIZE      = 32,
    parameter int PHT_INDEX_WIDTH = 11,
    parameter int GHR_WIDTH       = 10,
    parameter int PC_WIDTH        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       brValid,
    input  logic [PC_WIDTH-1:0]        brAddr,
    input  logic                       execTaken,
    input  logic                       isCondBr,
    input  logic [GHR_WIDTH-1:0]       globalHistory,
    input  logic [1:0]                 phtPrevValue,
    input  logic                       phtWriteGrant,
    output logic                       phtWE,
    output logic [PHT_INDEX_WIDTH-1:0] phtWA,
    output logic [1:0]                 phtWV,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(QUEUE_SIZE):0] count,
    output logic [15:0]                dropCount
);

    localparam int PTR_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PHT_INDEX_WIDTH-1:0] idx;
        logic [1:0]                 val;
    } entry_t;

    entry_t mem [QUEUE_SIZE];

    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [CNT_W-1:0]           cnt;
    logic [15:0]                drops;
    logic                       push;
    logic                       pop;
    logic                       accept;
    logic                       drop;
    logic [PHT_INDEX_WIDTH-1:0] ghExt;
    logic [PHT_INDEX_WIDTH-1:0] pushIdx;
    logic [1:0]                 pushVal;
    entry_t                     headEntry;
    logic                       unusedAddr;

    assign unusedAddr = ^{brAddr[PC_WIDTH-1:PHT_INDEX_WIDTH+2], brAddr[1:0]};

    // History is zero-extended so it folds into the low index bits only
    assign ghExt   = PHT_INDEX_WIDTH'(globalHistory);
    assign pushIdx = brAddr[PHT_INDEX_WIDTH+1:2] ^ ghExt;

    always_comb begin
        pushVal = phtPrevValue;
        if (execTaken) begin
            if (phtPrevValue != 2'd3) pushVal = phtPrevValue + 2'd1;
        end else begin
            if (phtPrevValue != 2'd0) pushVal = phtPrevValue - 2'd1;
        end
    end

    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_W'(QUEUE_SIZE));
    assign count  = cnt;
    assign dropCount = drops;

    assign push   = brValid && isCondBr;
    assign pop    = !empty && phtWriteGrant;
    // A pop in the same cycle frees the slot the push needs
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign headEntry = mem[head];
    assign phtWE = pop;
    assign phtWA = empty ? '0 : headEntry.idx;
    assign phtWV = empty ? '0 : headEntry.val;

    always_ff @(posedge clk) begin
        if (accept) mem[tail] <= '{idx: pushIdx, val: pushVal};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            drops <= '0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            unique case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
        end
    end

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: stimulus pushes expected writes,
// a negedge monitor pops and compares every PHT write the DUT issues.
module tb_pht_update_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        brValid;
    logic [31:0] brAddr;
    logic        execTaken;
    logic        isCondBr;
    logic [9:0]  globalHistory;
    logic [1:0]  phtPrevValue;
    logic        phtWriteGrant;
    logic        phtWE;
    logic [10:0] phtWA;
    logic [1:0]  phtWV;
    logic        full;
    logic        empty;
    logic [5:0]  count;
    logic [15:0] dropCount;

    int checks = 0;
    int failures = 0;
    logic [12:0] sb [$];

    pht_update_queue dut (
        .clk(clk), .rst(rst), .brValid(brValid), .brAddr(brAddr),
        .execTaken(execTaken), .isCondBr(isCondBr),
        .globalHistory(globalHistory), .phtPrevValue(phtPrevValue),
        .phtWriteGrant(phtWriteGrant), .phtWE(phtWE), .phtWA(phtWA),
        .phtWV(phtWV), .full(full), .empty(empty), .count(count),
        .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] satNext(logic [1:0] p, logic t);
        if (t) return (p == 2'd3) ? 2'd3 : p + 2'd1;
        return (p == 2'd0) ? 2'd0 : p - 2'd1;
    endfunction

    always @(negedge clk) begin
        if (!rst && phtWE) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {19'd0, phtWA, phtWV}, 32'hFFFF_FFFF);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                check("write_idx", 32'(phtWA), 32'(e[12:2]));
                check("write_val", 32'(phtWV), 32'(e[1:0]));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setPush(logic [31:0] a, logic [9:0] gh,
                           logic [1:0] p, logic t);
        brValid = 1'b1; isCondBr = 1'b1;
        brAddr = a; globalHistory = gh; phtPrevValue = p; execTaken = t;
    endtask

    task automatic idle();
        brValid = 1'b0; isCondBr = 1'b0;
    endtask

    task automatic waitEmpty(int budget);
        int n = 0;
        while (!empty && n < budget) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        rst = 1'b1; brValid = 1'b0; brAddr = '0; execTaken = 1'b0;
        isCondBr = 1'b0; globalHistory = '0; phtPrevValue = '0;
        phtWriteGrant = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_we", 32'(phtWE), 32'd0);
        check("rst_wa", 32'(phtWA), 32'd0);
        check("rst_wv", 32'(phtWV), 32'd0);
        cycle(); cycle();
        rst = 1'b0;

        // single update: 0x1000 ^ 0x003 history -> index 0x403, 1 -> 2
        phtWriteGrant = 1'b1;
        setPush(32'h1000, 10'h003, 2'd1, 1'b1);
        sb.push_back({11'h403, 2'd2});
        cycle();
        idle();
        check("single_we", 32'(phtWE), 32'd1);
        check("single_wa", 32'(phtWA), 32'h403);
        check("single_wv", 32'(phtWV), 32'd2);
        cycle();
        check("single_empty", 32'(empty), 32'd1);
        check("single_wa0", 32'(phtWA), 32'd0);

        // counter saturation corners
        setPush(32'h10, 10'h0, 2'd3, 1'b1); sb.push_back({11'd4, 2'd3});
        cycle();
        setPush(32'h20, 10'h0, 2'd0, 1'b0); sb.push_back({11'd8, 2'd0});
        cycle();
        setPush(32'h30, 10'h0, 2'd2, 1'b0); sb.push_back({11'd12, 2'd1});
        cycle();
        idle();
        waitEmpty(10);

        // fill with grant held off; the 33rd push is dropped
        phtWriteGrant = 1'b0;
        for (int k = 0; k < 33; k++) begin
            setPush(32'(k) << 2, 10'h0, 2'(k % 4), k[0]);
            if (k < 32) sb.push_back({11'(k), satNext(2'(k % 4), k[0])});
            cycle();
            if (k == 31) check("fill_full32", 32'(full), 32'd1);
        end
        idle();
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd32);
        check("fill_drop", 32'(dropCount), 32'd1);

        // push while full and popping is accepted without a drop
        phtWriteGrant = 1'b1;
        setPush(32'h1FC, 10'h0, 2'd2, 1'b1);
        sb.push_back({11'h07F, 2'd3});
        cycle();
        idle();
        check("simul_count", 32'(count), 32'd32);
        check("simul_drop", 32'(dropCount), 32'd1);
        waitEmpty(40);
        check("simul_sb", 32'(sb.size()), 32'd0);

        // asynchronous reset mid-cycle with 5 entries queued
        phtWriteGrant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            setPush(32'h2000 + (32'(k) << 2), 10'h0, 2'd1, 1'b1);
            sb.push_back({11'h000, 2'd2});
            cycle();
        end
        idle();
        check("pre_rst_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_we", 32'(phtWE), 32'd0);
        check("mid_rst_drop", 32'(dropCount), 32'd0);
        phtWriteGrant = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        check("post_rst_empty", 32'(empty), 32'd1);

        // filtering and pointer wrap with grant toggling each cycle
        for (int i = 0; i < 40; i++) begin
            logic [10:0] ix;
            phtWriteGrant = ~phtWriteGrant;
            setPush(32'(11'h100 + 11'(i)) << 2, 10'(i * 3), 2'(i % 4),
                    (i % 3) == 0);
            ix = (11'h100 + 11'(i)) ^ 11'(10'(i * 3));
            sb.push_back({ix, satNext(2'(i % 4), (i % 3) == 0)});
            cycle();
            phtWriteGrant = ~phtWriteGrant;
            brAddr = 32'h7FC; phtPrevValue = 2'd1;
            if (i[0]) begin
                brValid = 1'b1; isCondBr = 1'b0;
            end else begin
                brValid = 1'b0; isCondBr = 1'b1;
            end
            cycle();
        end
        idle();
        phtWriteGrant = 1'b1;
        waitEmpty(64);
        check("wrap_sb", 32'(sb.size()), 32'd0);
        check("wrap_drop", 32'(dropCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
